// File: rtl/npc_halt_reporter.sv
`default_nettype none
// ============================================================================
// Module  : npc_halt_reporter
// Brief   : Commit-side ebreak/timeout detector that drains, freezes the core
//           and delivers one pass/fail/timeout report over valid/ready.
// Revision: 1.0
// ============================================================================
module npc_halt_reporter #(
  parameter int XLEN         = 32,
  parameter int CNT_W        = 64,
  parameter int DRAIN_CYCLES = 4,
  parameter int TIMEOUT      = 1000000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             commit_valid,
  input  logic             commit_is_break,
  input  logic [XLEN-1:0]  commit_pc,
  input  logic [XLEN-1:0]  a0_value,
  input  logic             lsu_idle,
  output logic             halt_req,
  output logic             report_valid,
  input  logic             report_ready,
  output logic [1:0]       report_code,
  output logic [XLEN-1:0]  report_a0,
  output logic [XLEN-1:0]  report_pc,
  output logic [CNT_W-1:0] report_cycles,
  output logic [CNT_W-1:0] report_instret,
  output logic             done
);

  localparam int               c_DRAIN_W    = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
  localparam logic [c_DRAIN_W-1:0] c_DRAIN_LOAD = c_DRAIN_W'(DRAIN_CYCLES);
  localparam logic [c_DRAIN_W-1:0] c_DRAIN_ONE  = {{(c_DRAIN_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] c_CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] c_CNT_MAX    = {CNT_W{1'b1}};
  localparam logic             c_TO_EN      = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] c_TO_LAST    = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] c_CODE_PASS    = 2'b00;
  localparam logic [1:0] c_CODE_FAIL    = 2'b01;
  localparam logic [1:0] c_CODE_TIMEOUT = 2'b10;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_REPORT = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

  state_t               state_q;
  logic [CNT_W-1:0]     cycle_cnt_q;
  logic [CNT_W-1:0]     cycle_cnt_d;
  logic [CNT_W-1:0]     instret_q;
  logic [CNT_W-1:0]     instret_d;
  logic [XLEN-1:0]      last_pc_q;
  logic [XLEN-1:0]      last_pc_d;
  logic [c_DRAIN_W-1:0] drain_cnt_q;
  logic                 halt_req_q;
  logic                 report_valid_q;
  logic                 done_q;
  logic [1:0]           report_code_q;
  logic [XLEN-1:0]      report_a0_q;
  logic [XLEN-1:0]      report_pc_q;
  logic [CNT_W-1:0]     report_cycles_q;
  logic [CNT_W-1:0]     report_instret_q;

  logic                 w_break;
  logic                 w_timeout;
  logic                 w_drain_last;

  // Counter next-values are what a trigger captures, so the trigger cycle
  // and the ebreak itself are included in the report.
  always_comb begin
    cycle_cnt_d  = (cycle_cnt_q == c_CNT_MAX) ? cycle_cnt_q : cycle_cnt_q + c_CNT_ONE;
    instret_d    = instret_q;
    last_pc_d    = last_pc_q;
    if (commit_valid) begin
      last_pc_d = commit_pc;
      if (instret_q != c_CNT_MAX) begin
        instret_d = instret_q + c_CNT_ONE;
      end
    end
    w_break      = commit_valid && commit_is_break;
    w_timeout    = c_TO_EN && (cycle_cnt_q == c_TO_LAST) && !w_break;
    // Exit on the cycle the counter would reach zero: residency equals the load.
    w_drain_last = (drain_cnt_q <= c_DRAIN_ONE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q          <= ST_RUN;
      cycle_cnt_q      <= '0;
      instret_q        <= '0;
      last_pc_q        <= '0;
      drain_cnt_q      <= '0;
      halt_req_q       <= 1'b0;
      report_valid_q   <= 1'b0;
      done_q           <= 1'b0;
      report_code_q    <= '0;
      report_a0_q      <= '0;
      report_pc_q      <= '0;
      report_cycles_q  <= '0;
      report_instret_q <= '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          cycle_cnt_q <= cycle_cnt_d;
          instret_q   <= instret_d;
          last_pc_q   <= last_pc_d;
          if (w_break) begin
            report_code_q    <= (a0_value == '0) ? c_CODE_PASS : c_CODE_FAIL;
            report_a0_q      <= a0_value;
            report_pc_q      <= commit_pc;
            report_cycles_q  <= cycle_cnt_d;
            report_instret_q <= instret_d;
            drain_cnt_q      <= c_DRAIN_LOAD;
            halt_req_q       <= 1'b1;
            state_q          <= ST_DRAIN;
          end else if (w_timeout) begin
            report_code_q    <= c_CODE_TIMEOUT;
            report_a0_q      <= a0_value;
            report_pc_q      <= last_pc_d;
            report_cycles_q  <= cycle_cnt_d;
            report_instret_q <= instret_d;
            drain_cnt_q      <= c_DRAIN_LOAD;
            halt_req_q       <= 1'b1;
            state_q          <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (drain_cnt_q != '0) begin
            drain_cnt_q <= drain_cnt_q - c_DRAIN_ONE;
          end
          if (w_drain_last && lsu_idle) begin
            report_valid_q <= 1'b1;
            state_q        <= ST_REPORT;
          end
        end
        ST_REPORT: begin
          if (report_ready) begin
            report_valid_q <= 1'b0;
            done_q         <= 1'b1;
            state_q        <= ST_HALTED;
          end
        end
        ST_HALTED: begin
          state_q <= ST_HALTED;
        end
        default: begin
          state_q <= ST_RUN;
        end
      endcase
    end
  end

  assign halt_req       = halt_req_q;
  assign report_valid   = report_valid_q;
  assign done           = done_q;
  assign report_code    = report_code_q;
  assign report_a0      = report_a0_q;
  assign report_pc      = report_pc_q;
  assign report_cycles  = report_cycles_q;
  assign report_instret = report_instret_q;

endmodule
`default_nettype wire

// File: tb/tb_npc_halt_reporter.sv
`default_nettype none
// ============================================================================
// Module  : tb_npc_halt_reporter
// Brief   : Directed self-checking bench for npc_halt_reporter.
// Revision: 1.0
// ============================================================================
module tb_npc_halt_reporter;

  logic        clock;
  logic        reset;
  logic        rst_sat;
  logic        commit_valid;
  logic        commit_is_break;
  logic [31:0] commit_pc;
  logic [31:0] a0_value;
  logic        lsu_idle;
  logic        report_ready;

  logic        halt_req;
  logic        report_valid;
  logic [1:0]  report_code;
  logic [31:0] report_a0;
  logic [31:0] report_pc;
  logic [63:0] report_cycles;
  logic [63:0] report_instret;
  logic        done;

  logic        s_halt_req;
  logic        s_report_valid;
  logic [1:0]  s_report_code;
  logic [31:0] s_report_a0;
  logic [31:0] s_report_pc;
  logic [3:0]  s_report_cycles;
  logic [3:0]  s_report_instret;
  logic        s_done;

  int errors;
  int checks;

  npc_halt_reporter #(.XLEN(32), .CNT_W(64), .DRAIN_CYCLES(4), .TIMEOUT(100)) u_dut (
    .clock(clock), .reset(reset), .commit_valid(commit_valid), .commit_is_break(commit_is_break),
    .commit_pc(commit_pc), .a0_value(a0_value), .lsu_idle(lsu_idle), .halt_req(halt_req),
    .report_valid(report_valid), .report_ready(report_ready), .report_code(report_code),
    .report_a0(report_a0), .report_pc(report_pc), .report_cycles(report_cycles),
    .report_instret(report_instret), .done(done)
  );

  npc_halt_reporter #(.XLEN(32), .CNT_W(4), .DRAIN_CYCLES(4), .TIMEOUT(0)) u_sat (
    .clock(clock), .reset(rst_sat), .commit_valid(commit_valid), .commit_is_break(commit_is_break),
    .commit_pc(commit_pc), .a0_value(a0_value), .lsu_idle(lsu_idle), .halt_req(s_halt_req),
    .report_valid(s_report_valid), .report_ready(report_ready), .report_code(s_report_code),
    .report_a0(s_report_a0), .report_pc(s_report_pc), .report_cycles(s_report_cycles),
    .report_instret(s_report_instret), .done(s_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs;
    commit_valid    = 1'b0;
    commit_is_break = 1'b0;
  endtask

  task automatic do_reset;
    reset = 1'b0;
    idle_inputs();
    repeat (20) @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  // Cycles 1..n: commit when k%4 != 0 (37 commits in 49 cycles); on the other
  // cycles commit_is_break is raised without commit_valid and must be ignored.
  task automatic run_cycles(input int n);
    for (int k = 1; k <= n; k++) begin
      commit_valid    = (k % 4) != 0;
      commit_is_break = (k % 4) == 0;
      commit_pc       = 32'h8000_0000 + 32'(4 * k);
      a0_value        = 32'hDEAD_0000 + 32'(k);
      tick();
    end
    idle_inputs();
  endtask

  task automatic ebreak(input logic [31:0] a0, input logic [31:0] pc);
    commit_valid    = 1'b1;
    commit_is_break = 1'b1;
    commit_pc       = pc;
    a0_value        = a0;
    tick();
    idle_inputs();
  endtask

  task automatic test_reset;
    reset = 1'b0; rst_sat = 1'b0; idle_inputs();
    lsu_idle = 1'b1; report_ready = 1'b1; commit_pc = '0; a0_value = '0;
    #3;
    checks++; if (halt_req !== 1'b0) begin errors++; $display("FAIL reset_halt got=%b exp=0", halt_req); end
    checks++; if (report_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", report_valid); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if ({report_code, report_a0, report_pc} !== 66'd0) begin errors++; $display("FAIL reset_fields got=%h/%h/%h exp=0", report_code, report_a0, report_pc); end
    checks++; if ({report_cycles, report_instret} !== 128'd0) begin errors++; $display("FAIL reset_counts got=%0d/%0d exp=0", report_cycles, report_instret); end
    checks++; if ({s_halt_req, s_report_valid, s_done, s_report_cycles} !== 7'd0) begin errors++; $display("FAIL reset_sat got=%b%b%b/%h exp=0", s_halt_req, s_report_valid, s_done, s_report_cycles); end
  endtask

  // Shared pass/fail scenario: ebreak on cycle 50 after 37 commits.
  task automatic scen_ebreak(input logic [31:0] a0, input logic [1:0] code, input string tag);
    do_reset();
    lsu_idle = 1'b1; report_ready = 1'b1;
    run_cycles(49);
    checks++; if (halt_req !== 1'b0 || report_code !== 2'b00) begin errors++; $display("FAIL %s_pre got halt=%b code=%b exp 0/00", tag, halt_req, report_code); end
    ebreak(a0, 32'h8000_0094);
    checks++; if (halt_req !== 1'b1) begin errors++; $display("FAIL %s_halt got=%b exp=1", tag, halt_req); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (report_valid !== 1'b0) begin errors++; $display("FAIL %s_drain%0d valid got=%b exp=0", tag, i, report_valid); end
      tick();
    end
    checks++; if (report_valid !== 1'b1) begin errors++; $display("FAIL %s_valid got=%b exp=1", tag, report_valid); end
    checks++; if (report_code !== code) begin errors++; $display("FAIL %s_code got=%b exp=%b", tag, report_code, code); end
    checks++; if (report_a0 !== a0) begin errors++; $display("FAIL %s_a0 got=%h exp=%h", tag, report_a0, a0); end
    checks++; if (report_pc !== 32'h8000_0094) begin errors++; $display("FAIL %s_pc got=%h exp=80000094", tag, report_pc); end
    checks++; if (report_cycles !== 64'd50) begin errors++; $display("FAIL %s_cycles got=%0d exp=50", tag, report_cycles); end
    checks++; if (report_instret !== 64'd38) begin errors++; $display("FAIL %s_instret got=%0d exp=38", tag, report_instret); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL %s_done_early got=%b exp=0", tag, done); end
    tick();
    checks++; if (done !== 1'b1 || report_valid !== 1'b0 || halt_req !== 1'b1) begin errors++; $display("FAIL %s_halted got done=%b valid=%b halt=%b exp 1/0/1", tag, done, report_valid, halt_req); end
  endtask

  task automatic test_pass;
    scen_ebreak(32'h0, 2'b00, "pass");
  endtask

  task automatic test_fail;
    scen_ebreak(32'h1, 2'b01, "fail");
  endtask

  task automatic test_post_halt;
    for (int k = 0; k < 8; k++) begin
      commit_valid = 1'b1; commit_is_break = k[0]; commit_pc = 32'h9000_0000 + 32'(k); a0_value = 32'(k);
      tick();
    end
    idle_inputs();
    tick();
    checks++; if (done !== 1'b1 || halt_req !== 1'b1 || report_valid !== 1'b0) begin errors++; $display("FAIL post_state got done=%b halt=%b valid=%b exp 1/1/0", done, halt_req, report_valid); end
    checks++; if (report_code !== 2'b01 || report_a0 !== 32'h1 || report_pc !== 32'h8000_0094) begin errors++; $display("FAIL post_fields got=%b/%h/%h exp=01/1/80000094", report_code, report_a0, report_pc); end
    checks++; if (report_cycles !== 64'd50 || report_instret !== 64'd38) begin errors++; $display("FAIL post_counts got=%0d/%0d exp=50/38", report_cycles, report_instret); end
  endtask

  task automatic test_stall;
    do_reset();
    lsu_idle = 1'b1; report_ready = 1'b0;
    run_cycles(49);
    ebreak(32'h0000_0042, 32'h8000_0094);
    lsu_idle = 1'b0;
    for (int i = 0; i < 10; i++) begin
      checks++; if (report_valid !== 1'b0) begin errors++; $display("FAIL stall_wait%0d valid got=%b exp=0", i, report_valid); end
      tick();
    end
    lsu_idle = 1'b1;
    checks++; if (report_valid !== 1'b0) begin errors++; $display("FAIL stall_idle valid got=%b exp=0", report_valid); end
    tick();
    for (int i = 0; i < 5; i++) begin
      checks++; if (report_valid !== 1'b1 || report_code !== 2'b01 || report_a0 !== 32'h42 || report_pc !== 32'h8000_0094
                    || report_cycles !== 64'd50 || report_instret !== 64'd38)
        begin errors++; $display("FAIL stall_hold%0d got v=%b c=%b a0=%h pc=%h cy=%0d in=%0d exp 1/01/42/80000094/50/38",
                                 i, report_valid, report_code, report_a0, report_pc, report_cycles, report_instret); end
      commit_valid = 1'b1; commit_is_break = 1'b1; commit_pc = 32'h1234_0000; a0_value = 32'h0;
      tick();
    end
    idle_inputs();
    report_ready = 1'b1;
    checks++; if (report_valid !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL stall_accept got valid=%b done=%b exp 1/0", report_valid, done); end
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++; if (report_valid !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL stall_after%0d got valid=%b done=%b exp 0/1", i, report_valid, done); end
      tick();
    end
  endtask

  task automatic test_timeout;
    do_reset();
    lsu_idle = 1'b1; report_ready = 1'b1;
    run_cycles(100);
    checks++; if (halt_req !== 1'b1) begin errors++; $display("FAIL to_halt got=%b exp=1", halt_req); end
    repeat (4) tick();
    checks++; if (report_valid !== 1'b1 || report_code !== 2'b10) begin errors++; $display("FAIL to_code got valid=%b code=%b exp 1/10", report_valid, report_code); end
    checks++; if (report_cycles !== 64'd100 || report_instret !== 64'd75) begin errors++; $display("FAIL to_counts got=%0d/%0d exp=100/75", report_cycles, report_instret); end
    checks++; if (report_pc !== 32'h8000_018C || report_a0 !== 32'hDEAD_0064) begin errors++; $display("FAIL to_pc_a0 got=%h/%h exp=8000018c/dead0064", report_pc, report_a0); end
    // ebreak landing on the timeout cycle must take priority
    do_reset();
    run_cycles(99);
    ebreak(32'h0, 32'h8000_1000);
    repeat (4) tick();
    checks++; if (report_valid !== 1'b1 || report_code !== 2'b00) begin errors++; $display("FAIL to_race_code got valid=%b code=%b exp 1/00", report_valid, report_code); end
    checks++; if (report_pc !== 32'h8000_1000 || report_cycles !== 64'd100 || report_instret !== 64'd76) begin errors++; $display("FAIL to_race_fields got=%h/%0d/%0d exp=80001000/100/76", report_pc, report_cycles, report_instret); end
  endtask

  task automatic test_reset_mid;
    do_reset();
    lsu_idle = 1'b1; report_ready = 1'b0;
    run_cycles(49);
    ebreak(32'h3, 32'h8000_0094);
    repeat (4) tick();
    checks++; if (report_valid !== 1'b1) begin errors++; $display("FAIL mid_valid got=%b exp=1", report_valid); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if ({halt_req, report_valid, done, report_code} !== 5'd0 || {report_a0, report_pc} !== 64'd0
                  || {report_cycles, report_instret} !== 128'd0)
      begin errors++; $display("FAIL mid_async got halt=%b valid=%b done=%b code=%b a0=%h pc=%h exp all 0", halt_req, report_valid, done, report_code, report_a0, report_pc); end
    report_ready = 1'b1;
    scen_ebreak(32'h7, 2'b01, "mid_rerun");
  endtask

  task automatic test_saturation;
    rst_sat = 1'b1;
    lsu_idle = 1'b1; report_ready = 1'b1;
    run_cycles(24);
    ebreak(32'h0, 32'h8000_0200);
    checks++; if (s_report_cycles !== 4'hF || s_report_instret !== 4'hF) begin errors++; $display("FAIL sat_counts got=%h/%h exp=f/f", s_report_cycles, s_report_instret); end
    repeat (4) tick();
    checks++; if (s_report_valid !== 1'b1 || s_report_code !== 2'b00 || s_report_pc !== 32'h8000_0200) begin errors++; $display("FAIL sat_report got v=%b c=%b pc=%h exp 1/00/80000200", s_report_valid, s_report_code, s_report_pc); end
    tick();
    checks++; if (s_done !== 1'b1 || s_halt_req !== 1'b1 || s_report_a0 !== 32'h0) begin errors++; $display("FAIL sat_done got done=%b halt=%b a0=%h exp 1/1/0", s_done, s_halt_req, s_report_a0); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_pass();
    test_fail();
    test_post_halt();
    test_stall();
    test_timeout();
    test_reset_mid();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
